fwd_hazard_unit: RTL and testbench



---
 rtl/fwd_pkg.sv | 22 ++
 rtl/fwd_port_match.sv | 47 ++++
 rtl/fwd_hazard_unit.sv | 113 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and width helpers for the forwarding/hazard unit.
// Entry fields are sized for the largest supported configuration (256 registers, 255-stage latency).
package fwd_pkg;

    localparam int ENT_ADDR_W = 8;
    localparam int ENT_LAT_W  = 8;

    function automatic int reg_aw(input int reg_count);
        return (reg_count <= 2) ? 1 : $clog2(reg_count);
    endfunction

    function automatic int lat_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [ENT_ADDR_W-1:0] addr;
        logic [ENT_LAT_W-1:0]  rdy_cnt;
    } entry_t;

endpackage

// File: rtl/fwd_port_match.sv
// One read operand: find the youngest in-flight producer of its register and decide
// between a one-hot bypass select and a stall request.
module fwd_port_match
    import fwd_pkg::*;
#(
    parameter int FWD_DEPTH = 3,
    parameter int REG_AW    = 3,
    parameter bit ZERO_REG  = 1'b1
) (
    input  entry_t [FWD_DEPTH-1:0] ents,
    input  logic [REG_AW-1:0]      rd_addr,
    input  logic                   rd_used,
    output logic [FWD_DEPTH-1:0]   sel,
    output logic                   stall_req
);

    logic                 zero_hit;
    logic [FWD_DEPTH-1:0] match;
    logic [FWD_DEPTH-1:0] youngest;
    logic                 win_ready;

    assign zero_hit = ZERO_REG && (rd_addr == '0);

    always_comb begin
        match = '0;
        for (int i = 0; i < FWD_DEPTH; i++) begin
            match[i] = ents[i].valid && rd_used && !zero_hit &&
                       (ents[i].addr == ENT_ADDR_W'(rd_addr));
        end
    end

    // Two's-complement trick keeps only the lowest set bit, i.e. the youngest stage.
    assign youngest = match & (-match);

    always_comb begin
        win_ready = 1'b0;
        for (int i = 0; i < FWD_DEPTH; i++) begin
            if (youngest[i]) begin
                win_ready = (ents[i].rdy_cnt == '0);
            end
        end
    end

    assign sel       = win_ready ? youngest : '0;
    assign stall_req = (|youngest) && !win_ready;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks in-flight register writes in a short shift register and drives per-operand
// bypass selects, the issue stall and a saturating stall-cycle counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int READ_PORTS = 3,
    parameter int FWD_DEPTH  = 3,
    parameter int REG_COUNT  = 8,
    parameter bit ZERO_REG   = 1'b1,
    parameter int CNT_W      = 16,
    localparam int REG_AW    = reg_aw(REG_COUNT),
    localparam int LAT_W     = lat_w(FWD_DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clk_en,
    input  logic [READ_PORTS-1:0][REG_AW-1:0]    rd_addr,
    input  logic [READ_PORTS-1:0]                rd_used,
    input  logic                                 wr_valid,
    input  logic [REG_AW-1:0]                    wr_addr,
    input  logic [LAT_W-1:0]                     wr_lat,
    input  logic [FWD_DEPTH-1:0]                 flush_mask,
    input  logic                                 flush_issue,
    output logic [READ_PORTS-1:0][FWD_DEPTH-1:0] fwd_sel,
    output logic                                 stall,
    output logic [CNT_W-1:0]                     stall_cnt
);

    function automatic logic [ENT_LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        logic [ENT_LAT_W-1:0] ext;
        ext = ENT_LAT_W'(lat);
        return (ext > ENT_LAT_W'(FWD_DEPTH - 1)) ? ENT_LAT_W'(FWD_DEPTH - 1) : ext;
    endfunction

    function automatic logic [ENT_LAT_W-1:0] dec_sat(input logic [ENT_LAT_W-1:0] v);
        return (v == '0) ? v : v - ENT_LAT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    entry_t [FWD_DEPTH-1:0] ents;
    entry_t [FWD_DEPTH-1:0] kept;
    entry_t [FWD_DEPTH-1:0] ents_nxt;
    entry_t                 issue_ent;
    logic [READ_PORTS-1:0]  stall_req;
    logic                   load;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        fwd_port_match #(
            .FWD_DEPTH (FWD_DEPTH),
            .REG_AW    (REG_AW),
            .ZERO_REG  (ZERO_REG)
        ) u_match (
            .ents      (ents),
            .rd_addr   (rd_addr[p]),
            .rd_used   (rd_used[p]),
            .sel       (fwd_sel[p]),
            .stall_req (stall_req[p])
        );
    end

    assign stall = |stall_req;

    assign load = wr_valid && !stall && !flush_issue && !(ZERO_REG && (wr_addr == '0));

    always_comb begin
        issue_ent = '0;
        if (load) begin
            issue_ent.valid   = 1'b1;
            issue_ent.addr    = ENT_ADDR_W'(wr_addr);
            issue_ent.rdy_cnt = clamp_lat(wr_lat);
        end
    end

    // Flush acts on the entries where they sit now, before any shift.
    always_comb begin
        kept = ents;
        for (int i = 0; i < FWD_DEPTH; i++) begin
            kept[i].valid = ents[i].valid && !flush_mask[i];
        end
    end

    // The oldest stage falls off the end: the register file holds that result now.
    always_comb begin
        ents_nxt = kept;
        if (clk_en) begin
            ents_nxt[0] = issue_ent;
            for (int i = 1; i < FWD_DEPTH; i++) begin
                ents_nxt[i]         = kept[i-1];
                ents_nxt[i].rdy_cnt = dec_sat(kept[i-1].rdy_cnt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ents <= '0;
        end else begin
            ents <= ents_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (clk_en && stall) begin
            stall_cnt <= inc_sat(stall_cnt);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios plus random traffic against an
// age-based queue model of in-flight writes.
module tb_fwd_hazard_unit;

    localparam int RP = 3;
    localparam int FD = 3;
    localparam int AW = 3;
    localparam int LW = 2;

    logic                   clk;
    logic                   rst_n;
    logic                   clk_en;
    logic [RP-1:0][AW-1:0]  rd_addr;
    logic [RP-1:0]          rd_used;
    logic                   wr_valid;
    logic [AW-1:0]          wr_addr;
    logic [LW-1:0]          wr_lat;
    logic [FD-1:0]          flush_mask;
    logic                   flush_issue;
    logic [RP-1:0][FD-1:0]  fwd_sel, fwd_sel_nz, fwd_sel_sat;
    logic                   stall, stall_nz, stall_sat;
    logic [15:0]            stall_cnt, stall_cnt_nz;
    logic [1:0]             stall_cnt_sat;

    int total;
    int bad;

    typedef struct {
        int addr;
        int lat;
        int age;
    } mw_t;
    mw_t mq[$];
    int  m_cnt;
    int  m_cnt_sat;

    fwd_hazard_unit #(.READ_PORTS(RP), .FWD_DEPTH(FD), .REG_COUNT(8), .ZERO_REG(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .rd_addr(rd_addr), .rd_used(rd_used),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_lat(wr_lat), .flush_mask(flush_mask),
        .flush_issue(flush_issue), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt));

    fwd_hazard_unit #(.READ_PORTS(RP), .FWD_DEPTH(FD), .REG_COUNT(8), .ZERO_REG(1'b0), .CNT_W(16)) dut_nz (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .rd_addr(rd_addr), .rd_used(rd_used),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_lat(wr_lat), .flush_mask(flush_mask),
        .flush_issue(flush_issue), .fwd_sel(fwd_sel_nz), .stall(stall_nz), .stall_cnt(stall_cnt_nz));

    fwd_hazard_unit #(.READ_PORTS(RP), .FWD_DEPTH(FD), .REG_COUNT(8), .ZERO_REG(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .rd_addr(rd_addr), .rd_used(rd_used),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_lat(wr_lat), .flush_mask(flush_mask),
        .flush_issue(flush_issue), .fwd_sel(fwd_sel_sat), .stall(stall_sat), .stall_cnt(stall_cnt_sat));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Youngest producer per operand; it is forwardable once its age reaches its latency.
    function automatic void model_eval(output logic [RP-1:0][FD-1:0] sel, output logic stl);
        int best_age;
        int best_lat;
        sel = '0;
        stl = 1'b0;
        for (int p = 0; p < RP; p++) begin
            best_age = FD;
            best_lat = 0;
            if (rd_used[p] && rd_addr[p] != 0) begin
                foreach (mq[k]) begin
                    if (mq[k].addr == int'(rd_addr[p]) && mq[k].age < best_age) begin
                        best_age = mq[k].age;
                        best_lat = mq[k].lat;
                    end
                end
            end
            if (best_age < FD) begin
                if (best_age >= best_lat) sel[p][best_age] = 1'b1;
                else stl = 1'b1;
            end
        end
    endfunction

    task automatic idle();
        clk_en      = 1'b1;
        rd_addr     = '0;
        rd_used     = '0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_lat      = '0;
        flush_mask  = '0;
        flush_issue = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        mq.delete();
        m_cnt     = 0;
        m_cnt_sat = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance the model with the inputs currently applied, then take one clock edge.
    task automatic step();
        logic [RP-1:0][FD-1:0] s;
        logic st;
        int   l;
        model_eval(s, st);
        for (int k = mq.size() - 1; k >= 0; k--) begin
            if (flush_mask[mq[k].age]) mq.delete(k);
        end
        if (clk_en) begin
            foreach (mq[k]) mq[k].age++;
            for (int k = mq.size() - 1; k >= 0; k--) begin
                if (mq[k].age >= FD) mq.delete(k);
            end
            if (wr_valid && !st && !flush_issue && wr_addr != 0) begin
                l = int'(wr_lat);
                if (l > FD - 1) l = FD - 1;
                mq.push_back('{int'(wr_addr), l, 0});
            end
            if (st) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_sat < 3) m_cnt_sat++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n   = 1'b0;
        rd_used = '1;
        rd_addr = {3'd1, 3'd2, 3'd3};
        #1;
        total++; if (fwd_sel !== '0) begin bad++; $display("FAIL reset_fwd_sel got=%b exp=0", fwd_sel); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        total++; if (stall_cnt_nz !== 16'd0) begin bad++; $display("FAIL reset_cnt_nz got=%0d exp=0", stall_cnt_nz); end
        do_reset();
        step();
        total++; if (fwd_sel !== '0) begin bad++; $display("FAIL reset_empty_sel got=%b exp=0", fwd_sel); end
    endtask

    task automatic test_back_to_back();
        logic [FD-1:0] exp_seq [4];
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b000};
        do_reset();
        wr_valid = 1'b1; wr_addr = 3'd3; wr_lat = 2'd0;
        step();
        wr_valid = 1'b0;
        rd_addr[0] = 3'd3; rd_used[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++; if (fwd_sel[0] !== exp_seq[c]) begin bad++; $display("FAIL b2b_sel c=%0d got=%b exp=%b", c, fwd_sel[0], exp_seq[c]); end
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall c=%0d got=%b exp=0", c, stall); end
            step();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        wr_valid = 1'b1; wr_addr = 3'd5; wr_lat = 2'd1;
        step();
        wr_valid = 1'b0;
        rd_addr[1] = 3'd5; rd_used[1] = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall); end
        total++; if (fwd_sel !== '0) begin bad++; $display("FAIL lu_sel_stalled got=%b exp=0", fwd_sel); end
        step();
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
        total++; if (fwd_sel[1] !== 3'b010) begin bad++; $display("FAIL lu_sel got=%b exp=010", fwd_sel[1]); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_resolved got=%b exp=0", stall); end
    endtask

    task automatic test_lat_clamp();
        do_reset();
        wr_valid = 1'b1; wr_addr = 3'd7; wr_lat = 2'd3;
        step();
        wr_valid = 1'b0;
        rd_addr[2] = 3'd7; rd_used[2] = 1'b1;
        step();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL clamp_stall got=%b exp=1", stall); end
        step();
        total++; if (fwd_sel[2] !== 3'b100) begin bad++; $display("FAIL clamp_sel got=%b exp=100", fwd_sel[2]); end
    endtask

    task automatic test_youngest();
        do_reset();
        wr_valid = 1'b1; wr_addr = 3'd2; wr_lat = 2'd0;
        step();
        step();
        wr_valid = 1'b0;
        rd_addr[2] = 3'd2; rd_used[2] = 1'b1;
        #1;
        total++; if (fwd_sel[2] !== 3'b001) begin bad++; $display("FAIL young_sel got=%b exp=001", fwd_sel[2]); end
        clk_en = 1'b0; flush_mask = 3'b001;
        step();
        flush_mask = '0;
        #1;
        total++; if (fwd_sel[2] !== 3'b010) begin bad++; $display("FAIL young_flush got=%b exp=010", fwd_sel[2]); end
        clk_en = 1'b1;
        wr_valid = 1'b1; wr_addr = 3'd4; flush_issue = 1'b1;
        step();
        wr_valid = 1'b0; flush_issue = 1'b0;
        rd_addr[0] = 3'd4; rd_used[0] = 1'b1;
        #1;
        total++; if (fwd_sel[0] !== 3'b000) begin bad++; $display("FAIL flush_issue got=%b exp=000", fwd_sel[0]); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        wr_valid = 1'b1; wr_addr = 3'd0; wr_lat = 2'd0;
        step();
        wr_valid = 1'b0;
        rd_addr = '0; rd_used = '1;
        #1;
        total++; if (fwd_sel !== '0) begin bad++; $display("FAIL zero_sel got=%b exp=0", fwd_sel); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL zero_stall got=%b exp=0", stall); end
        total++; if (fwd_sel_nz !== {3'b001, 3'b001, 3'b001}) begin bad++; $display("FAIL zero_nz_sel got=%b exp=001001001", fwd_sel_nz); end
        total++; if (stall_nz !== 1'b0) begin bad++; $display("FAIL zero_nz_stall got=%b exp=0", stall_nz); end
    endtask

    task automatic test_clk_en_ageout();
        logic [FD-1:0] exp_seq [3];
        exp_seq = '{3'b010, 3'b100, 3'b000};
        do_reset();
        wr_valid = 1'b1; wr_addr = 3'd6; wr_lat = 2'd0;
        step();
        wr_valid = 1'b1; wr_addr = 3'd6;
        clk_en = 1'b0;
        rd_addr[0] = 3'd6; rd_used[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (fwd_sel[0] !== 3'b001) begin bad++; $display("FAIL hold_sel c=%0d got=%b exp=001", c, fwd_sel[0]); end
            step();
        end
        wr_valid = 1'b0;
        clk_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (fwd_sel[0] !== exp_seq[c]) begin bad++; $display("FAIL age_sel c=%0d got=%b exp=%b", c, fwd_sel[0], exp_seq[c]); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        wr_valid = 1'b1; wr_addr = 3'd1; wr_lat = 2'd2;
        rd_addr[0] = 3'd1; rd_used[0] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            total++; if (stall_sat !== stall) begin bad++; $display("FAIL sat_stall_agree c=%0d got=%b exp=%b", c, stall_sat, stall); end
            step();
        end
        total++; if (stall_cnt !== 16'd6) begin bad++; $display("FAIL sat_cnt_wide got=%0d exp=6", stall_cnt); end
        total++; if (stall_cnt_sat !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d exp=3", stall_cnt_sat); end
        for (int c = 0; c < 3; c++) step();
        total++; if (stall_cnt !== 16'd8) begin bad++; $display("FAIL sat_cnt_wide2 got=%0d exp=8", stall_cnt); end
        total++; if (stall_cnt_sat !== 2'd3) begin bad++; $display("FAIL sat_hold got=%0d exp=3", stall_cnt_sat); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        wr_valid = 1'b1; wr_addr = 3'd5; wr_lat = 2'd2;
        step();
        wr_valid = 1'b0;
        rd_addr[0] = 3'd5; rd_used[0] = 1'b1;
        step();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mid_pre_stall got=%b exp=1", stall); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mid_stall got=%b exp=0", stall); end
        total++; if (fwd_sel !== '0) begin bad++; $display("FAIL mid_sel got=%b exp=0", fwd_sel); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", stall_cnt); end
        mq.delete();
        m_cnt = 0;
        m_cnt_sat = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [RP-1:0][FD-1:0] es;
        logic est;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            for (int p = 0; p < RP; p++) begin
                rd_addr[p] = AW'($urandom_range(0, 7));
                rd_used[p] = ($urandom_range(0, 3) != 0);
            end
            wr_valid    = ($urandom_range(0, 3) != 0);
            wr_addr     = AW'($urandom_range(0, 7));
            wr_lat      = LW'($urandom_range(0, 3));
            flush_mask  = ($urandom_range(0, 7) == 0) ? FD'($urandom_range(1, 7)) : '0;
            flush_issue = ($urandom_range(0, 9) == 0);
            clk_en      = ($urandom_range(0, 4) != 0);
            #1;
            model_eval(es, est);
            total++; if (fwd_sel !== es) begin bad++; $display("FAIL rnd_sel n=%0d got=%b exp=%b", n, fwd_sel, es); end
            total++; if (stall !== est) begin bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall, est); end
            total++; if (stall_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, stall_cnt, m_cnt); end
            total++; if (stall_cnt_sat !== 2'(m_cnt_sat)) begin bad++; $display("FAIL rnd_cnt_sat n=%0d got=%0d exp=%0d", n, stall_cnt_sat, m_cnt_sat); end
            step();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst_n = 1'b0;
        mq.delete();
        m_cnt = 0;
        m_cnt_sat = 0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_lat_clamp();
        test_youngest();
        test_zero_reg();
        test_clk_en_ageout();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
